imem_fetch_ctrl: RTL

//  Owns the single port of the 512-word instructionMemory and sequences it.

---
 rtl/imem_fetch_ctrl_if.sv | 25 ++
 rtl/imem_fetch_ctrl.sv | 67 ++++++
 2 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: loader, instruction-memory and decode-handshake signals of the fetch controller
interface imem_fetch_ctrl_if #(parameter int ADDR_W = 9);
    logic              load_en;
    logic [ADDR_W-1:0] load_addr;
    logic [31:0]       load_data;
    logic              load_ack;
    logic [31:0]       mem_addr;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic              if_valid;
    logic              if_ready;
    logic [31:0]       if_instr;
    logic [31:0]       if_pc;
    modport master (
        input  load_en, load_addr, load_data, mem_rdata, redirect, redirect_pc, if_ready,
        output load_ack, mem_addr, mem_we, mem_wdata, if_valid, if_instr, if_pc
    );
    modport slave (
        output load_en, load_addr, load_data, mem_rdata, redirect, redirect_pc, if_ready,
        input  load_ack, mem_addr, mem_we, mem_wdata, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the instruction memory port; loads a program, then fetches one word per cycle to decode
module imem_fetch_ctrl #(
    parameter int ADDR_W   = 9,
    parameter int RESET_PC = 0,
    parameter int PC_INC   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                halt,
    output logic [1:0]          state,
    imem_fetch_ctrl_if.master   bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, HALTED = 2'd3} state_t;
    state_t            cur, nxt;
    logic [ADDR_W-1:0] pc, ipc;
    logic [31:0]       instr;
    logic              valid, fire, wr;
    logic              unused_redirect_hi;
    assign unused_redirect_hi = ^bus.redirect_pc[31:ADDR_W];
    assign fire = !valid || bus.if_ready;
    always_ff @(posedge clk) begin
        if (reset) cur <= IDLE;
        else cur <= nxt;
    end
    always_comb begin
        nxt = cur;
        case (cur)
            IDLE:    nxt = bus.load_en ? LOAD : start ? RUN : IDLE;
            LOAD:    nxt = bus.load_en ? LOAD : IDLE;
            RUN:     nxt = halt ? HALTED : RUN;
            default: nxt = HALTED;
        endcase
    end
    // the reset cycle must never write, even if a load was in progress
    always_comb begin
        wr            = !reset && cur == LOAD && bus.load_en;
        bus.load_ack  = wr;
        bus.mem_we    = wr;
        bus.mem_addr  = cur == LOAD ? 32'(bus.load_addr) : 32'(pc);
        bus.mem_wdata = (!reset && cur == LOAD) ? bus.load_data : 32'd0;
        state         = cur;
        bus.if_valid  = valid;
        bus.if_instr  = instr;
        bus.if_pc     = 32'(ipc);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= ADDR_W'(RESET_PC);
            ipc   <= '0;
            instr <= '0;
            valid <= 1'b0;
        end else if (cur == RUN) begin
            if (bus.redirect) begin
                pc    <= bus.redirect_pc[ADDR_W-1:0];
                valid <= 1'b0;
            end else if (fire) begin
                instr <= bus.mem_rdata;
                ipc   <= pc;
                valid <= 1'b1;
                pc    <= pc + ADDR_W'(PC_INC);
            end
        end else if (cur == HALTED && bus.if_ready) begin
            valid <= 1'b0;
        end
    end
endmodule
